// File: rtl/qam_pkg.sv
// Shared types and defaults for the QAM demodulator sample controller.
package qam_pkg;

  localparam int SAMPLE_W       = 10;  // signed 3Q6 samples
  localparam int CNT_W          = 16;  // sample / flush counter width
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int SAMPLE_DIV_DEF = 4;
  localparam int FLUSH_LEN_DEF  = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } qam_state_e;

endpackage

// File: rtl/qam_sample_fifo.sv
// First-word-fall-through sample buffer: data always shows the oldest
// entry while empty is low. Pushes on full and pops on empty are dropped
// internally; clr empties the buffer and wins over a same-cycle push.
module qam_sample_fifo
  import qam_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    push,
  input  sample_t wdata,
  input  logic    pop,
  output sample_t data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign data  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/qam_demod_ctrl.sv
// Frame controller feeding the demod datapath: pulls buffered samples at
// one strobe slot every SAMPLE_DIV clocks, then drains the filter pipeline
// with FLUSH_LEN zero strobes.
//
// Upstream handshake: a sample transfers on a rising edge where
// s_valid && s_ready; s_ready reflects only buffer space (low in reset),
// and s_data must hold while s_valid is high and s_ready is low.
module qam_demod_ctrl
  import qam_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int FLUSH_LEN  = FLUSH_LEN_DEF
) (
  input  logic                axi_clk,
  input  logic                axi_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cfg_frame_len,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                qam_valid,
  output logic [SAMPLE_W-1:0] qam_in,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output qam_state_e          state_dbg
);

  localparam int                DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

  qam_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [SAMPLE_W-1:0]   qam_in_q, qam_in_d;
  logic                  qam_valid_q, qam_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underrun_q, underrun_d;

  logic                  slot;
  logic                  fifo_push, fifo_pop, fifo_clr;
  logic                  fifo_full, fifo_empty;
  sample_t               fifo_data;

  assign slot       = (div_q == DIV_LAST);
  assign s_ready    = !fifo_full && !axi_rst;
  assign fifo_push  = s_valid && s_ready;
  assign qam_valid  = qam_valid_q;
  assign qam_in     = qam_in_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign state_dbg  = state_q;

  qam_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (s_data),
    .pop   (fifo_pop),
    .data  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, divider, counters and strobe generation.
  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    cnt_d        = cnt_q;
    flush_cnt_d  = flush_cnt_q;
    len_d        = len_q;
    qam_in_d     = qam_in_q;
    qam_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    fifo_pop     = 1'b0;
    fifo_clr     = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      flush_cnt_d = '0;
      fifo_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (cfg_frame_len != '0)) begin
            state_d     = ST_RUN;
            len_d       = cfg_frame_len;
            cnt_d       = '0;
            flush_cnt_d = '0;
            underrun_d  = 1'b0;
          end
        end
        ST_RUN: begin
          div_d = slot ? '0 : div_q + DIV_W'(1);
          if (slot) begin
            if (!fifo_empty) begin
              fifo_pop    = 1'b1;
              qam_valid_d = 1'b1;
              qam_in_d    = fifo_data;
              cnt_d       = cnt_q + CNT_W'(1);
              if ((cnt_q + CNT_W'(1)) == len_q) state_d = ST_FLUSH;
            end else begin
              // Empty slot is skipped so the cordic phase only advances on real samples.
              underrun_d = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          div_d = slot ? '0 : div_q + DIV_W'(1);
          if (slot) begin
            qam_valid_d = 1'b1;
            qam_in_d    = '0;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
            if (flush_cnt_q == FLUSH_LAST) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          flush_cnt_d  = '0;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      flush_cnt_q  <= '0;
      len_q        <= '0;
      qam_in_q     <= '0;
      qam_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      len_q        <= len_d;
      qam_in_q     <= qam_in_d;
      qam_valid_q  <= qam_valid_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_qam_demod_ctrl.sv
// Bench for qam_demod_ctrl: default instance checked every cycle against a
// frame-level model, plus a SAMPLE_DIV=1 instance with literal expectations.
module tb_qam_demod_ctrl;
  import qam_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DIV    = 4;
  localparam int FLEN   = 32;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DONE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        axi_rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [15:0] cfg_frame_len = '0;
  logic [9:0]  s_data = '0;
  logic        s_ready, qam_valid, busy, frame_done, underrun;
  logic [9:0]  qam_in;
  qam_state_e  state_dbg;

  logic        start1 = 1'b0, abort1 = 1'b0, s_valid1 = 1'b0;
  logic [15:0] cfg_frame_len1 = '0;
  logic [9:0]  s_data1 = '0;
  logic        s_ready1, qam_valid1, busy1, frame_done1, underrun1;
  logic [9:0]  qam_in1;
  qam_state_e  state_dbg1;

  qam_demod_ctrl dut (
    .axi_clk(clk), .axi_rst(axi_rst), .start(start), .abort(abort),
    .cfg_frame_len(cfg_frame_len), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .qam_valid(qam_valid), .qam_in(qam_in), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .state_dbg(state_dbg)
  );

  qam_demod_ctrl #(.FIFO_DEPTH(4), .SAMPLE_DIV(1), .FLUSH_LEN(4)) dut1 (
    .axi_clk(clk), .axi_rst(axi_rst), .start(start1), .abort(abort1),
    .cfg_frame_len(cfg_frame_len1), .s_valid(s_valid1), .s_ready(s_ready1),
    .s_data(s_data1), .qam_valid(qam_valid1), .qam_in(qam_in1), .busy(busy1),
    .frame_done(frame_done1), .underrun(underrun1), .state_dbg(state_dbg1)
  );

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [9:0] exp_q[$];          // samples the buffer must hold
  int         m_mode = M_IDLE;
  int         m_t, m_issued, m_len, m_flushed;
  logic       e_valid = 1'b0, e_done = 1'b0, e_under = 1'b0;
  logic [9:0] e_data = '0;

  always @(posedge clk) begin
    bit do_push;
    do_push = s_valid && !axi_rst && (exp_q.size() < DEPTH);
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (axi_rst) begin
      exp_q.delete();
      m_mode  = M_IDLE;
      e_data  = '0;
      e_under = 1'b0;
    end else if (abort) begin
      exp_q.delete();
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (start && cfg_frame_len != 0) begin
          m_mode = M_RUN; m_t = 0; m_issued = 0; m_flushed = 0;
          m_len = cfg_frame_len; e_under = 1'b0;
        end
        M_RUN: begin
          m_t++;
          if (m_t % DIV == 0) begin
            if (exp_q.size() > 0) begin
              e_data = exp_q.pop_front(); e_valid = 1'b1; m_issued++;
              if (m_issued == m_len) m_mode = M_FLUSH;
            end else e_under = 1'b1;
          end
        end
        M_FLUSH: begin
          m_t++;
          if (m_t % DIV == 0) begin
            e_data = '0; e_valid = 1'b1; m_flushed++;
            if (m_flushed == FLEN) m_mode = M_DONE;
          end
        end
        default: begin e_done = 1'b1; m_mode = M_IDLE; end
      endcase
      if (do_push) exp_q.push_back(s_data);
    end
  end

  // ---------------- compare process + strobe logs ----------------
  int         sc_q[$], sc1_q[$];
  logic [9:0] sd_q[$], sd1_q[$];
  int         done_cyc = -1, done1_cyc = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("qam_valid",  qam_valid,  e_valid);
      chk("qam_in",     qam_in,     e_data);
      chk("busy",       busy,       (m_mode == M_RUN || m_mode == M_FLUSH));
      chk("frame_done", frame_done, e_done);
      chk("underrun",   underrun,   e_under);
      chk("s_ready",    s_ready,    (!axi_rst && exp_q.size() < DEPTH));
      if (qam_valid) begin sc_q.push_back(cyc); sd_q.push_back(qam_in); end
      if (frame_done) done_cyc = cyc;
      if (qam_valid1) begin sc1_q.push_back(cyc); sd1_q.push_back(qam_in1); end
      if (frame_done1) done1_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_sample(input logic [9:0] v);
    s_valid = 1'b1; s_data = v; tick(); s_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] len, output int t);
    start = 1'b1; cfg_frame_len = len; t = cyc; tick(); start = 1'b0;
  endtask

  task automatic clear_logs();
    sc_q.delete(); sd_q.delete(); sc1_q.delete(); sd1_q.delete();
    done_cyc = -1; done1_cyc = -1;
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done_cyc >= 0) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_strobes(input string name, input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (sc_q.size() >= n) return;
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int n;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_s_ready_low", s_ready, 1'b0);
    tick();
    axi_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1'b1);
    chk("post_rst_qam_in", qam_in, 10'd0);
    tick();

    // Nominal frame: 8 samples then 32 zero strobes.
    clear_logs();
    for (int i = 1; i <= 8; i++) push_sample(10'(i));
    start_frame(16'd8, t0);
    wait_done("frame8", 400);
    tick();
    chk("f8_strobe_count", sc_q.size(), 40);
    chk("f8_first_cycle", sc_q[0] - t0, 5);
    chk("f8_last_data_cycle", sc_q[7] - t0, 33);
    chk("f8_first_flush_cycle", sc_q[8] - t0, 37);
    chk("f8_last_flush_cycle", sc_q[39] - t0, 161);
    chk("f8_done_cycle", done_cyc - t0, 162);
    for (int i = 0; i < 8; i++) chk("f8_data", sd_q[i], 10'(i + 1));
    chk("f8_flush_zero", sd_q[20], 10'd0);

    // Late sample: one slot skipped, underrun raised.
    clear_logs();
    push_sample(10'd10);
    push_sample(10'd20);
    start_frame(16'd4, t0);
    while (cyc < t0 + 13) tick();
    push_sample(10'd30);
    push_sample(10'h3FB);
    wait_done("late", 400);
    tick();
    chk("late_strobe_count", sc_q.size(), 36);
    chk("late_d0", sd_q[0], 10'd10);
    chk("late_d1", sd_q[1], 10'd20);
    chk("late_d2", sd_q[2], 10'd30);
    chk("late_d3", sd_q[3], 10'h3FB);
    chk("late_gap", sc_q[2] - sc_q[1], 8);
    chk("late_underrun", underrun, 1'b1);

    // Fill to full with no start, then drain through a 16-sample frame.
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 10'(100 + i); tick();
    end
    s_data = 10'd116;
    tick(); tick();
    @(negedge clk);
    chk("full_s_ready", s_ready, 1'b0);
    tick();
    s_valid = 1'b0;
    start_frame(16'd16, t0);
    while (cyc < t0 + 4) tick();
    @(negedge clk);
    chk("full_before_pop", s_ready, 1'b0);
    @(negedge clk);
    chk("full_after_pop", s_ready, 1'b1);
    wait_done("full", 600);
    tick();
    chk("full_strobe_count", sc_q.size(), 48);
    for (int i = 0; i < 16; i++) chk("full_data", sd_q[i], 10'(100 + i));

    // Abort in FLUSH with samples pending.
    clear_logs();
    push_sample(10'd1); push_sample(10'd2); push_sample(10'd3);
    start_frame(16'd2, t0);
    wait_strobes("abort_wait", 3, 100);
    tick();
    push_sample(10'd7);
    push_sample(10'd8);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk("abort_state", state_dbg, ST_IDLE);
    chk("abort_busy", busy, 1'b0);
    chk("abort_no_done", frame_done, 1'b0);
    repeat (40) tick();
    chk("abort_never_done", done_cyc, -1);
    n = sc_q.size();
    start_frame(16'd1, t0);
    repeat (12) tick();
    chk("abort_empty_no_strobe", sc_q.size(), n);
    chk("abort_empty_underrun", underrun, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk("abort_keeps_underrun", underrun, 1'b1);
    tick();

    // Zero-length start is ignored.
    clear_logs();
    push_sample(10'd55);
    start_frame(16'd0, t0);
    repeat (10) tick();
    chk("len0_busy", busy, 1'b0);
    chk("len0_state", state_dbg, ST_IDLE);
    chk("len0_no_strobe", sc_q.size(), 0);
    start_frame(16'd1, t0);
    wait_done("len1", 300);
    tick();
    chk("len1_data", sd_q[0], 10'd55);
    chk("len1_underrun_clear", underrun, 1'b0);

    // Reset in RUN with 5 samples buffered.
    clear_logs();
    for (int i = 0; i < 7; i++) push_sample(10'(200 + i));
    start_frame(16'd7, t0);
    wait_strobes("rst_wait", 2, 100);
    tick();
    axi_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_s_ready", s_ready, 1'b0);
    tick();
    axi_rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", qam_valid, 1'b0);
    chk("rst_mid_qam_in", qam_in, 10'd0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", frame_done, 1'b0);
    chk("rst_mid_underrun", underrun, 1'b0);
    chk("rst_mid_ready", s_ready, 1'b1);
    tick();
    n = sc_q.size();
    start_frame(16'd3, t0);
    repeat (20) tick();
    chk("rst_then_no_strobe", sc_q.size(), n);
    chk("rst_then_underrun", underrun, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;

    // SAMPLE_DIV=1 instance: strobes on consecutive cycles.
    clear_logs();
    @(negedge clk);
    chk("d1_ready", s_ready1, 1'b1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      s_valid1 = 1'b1; s_data1 = 10'(i); tick();
    end
    s_valid1 = 1'b0;
    start1 = 1'b1; cfg_frame_len1 = 16'd3; t0 = cyc; tick(); start1 = 1'b0;
    repeat (12) tick();
    chk("d1_strobe_count", sc1_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk("d1_cycle", sc1_q[i] - t0, 2 + i);
      chk("d1_data", sd1_q[i], (i < 3) ? 10'(i + 1) : 10'd0);
    end
    chk("d1_done_cycle", done1_cyc - t0, 9);
    chk("d1_busy", busy1, 1'b0);
    chk("d1_underrun", underrun1, 1'b0);
    chk("d1_state", state_dbg1, ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_demod_ctrl.md
QAM_DEMOD_CTRL -- requirements
Module: qam_demod_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, input sample buffer depth (power of 2, >=4).
REQ-002 SHALL have parameter SAMPLE_DIV, default 4, clocks per demod strobe (>=1).
REQ-003 SHALL have parameter FLUSH_LEN, default 32, zero samples issued after each frame to drain the filter pipeline.
REQ-004 SHALL have port axi_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port axi_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  frame start request, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  abandon the current frame; highest priority after reset.
REQ-008 SHALL have port cfg_frame_len  input  16  samples per frame, latched when start is accepted.
REQ-009 SHALL have port s_valid  input  1  upstream sample valid.
REQ-010 SHALL have port s_ready  output  1  buffer can accept a sample.
REQ-011 SHALL have port s_data  input  10  signed sample, 3Q6.
REQ-012 SHALL have port qam_valid  output  1  one-cycle strobe to the demod datapath (drives its cordic enable).
REQ-013 SHALL have port qam_in  output  10  signed sample to the datapath, 3Q6.
REQ-014 SHALL have port busy  output  1  high in RUN and FLUSH.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 SHALL have port underrun  output  1  sticky: a strobe slot found the buffer empty in RUN.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE -> RUN when start=1 and cfg_frame_len!=0; start with cfg_frame_len=0 SHALL be ignored.
REQ-019 A divider SHALL be 0 on RUN entry and count 0..SAMPLE_DIV-1 in RUN and FLUSH; its terminal count is a strobe slot.
REQ-020 RUN slot with buffer non-empty: pop one sample; next cycle qam_valid=1 and qam_in=sample; sample counter +1.
REQ-021 RUN slot with buffer empty: no pop, qam_valid=0, underrun set, sample counter unchanged; this keeps the cordic phase aligned to real samples.
REQ-022 start accepted at cycle T: first possible qam_valid at T+SAMPLE_DIV+1.
REQ-023 RUN -> FLUSH on the slot that issues sample cfg_frame_len; FLUSH SHALL issue FLUSH_LEN strobes with qam_in=0 at the same cadence, none from the buffer.
REQ-024 FLUSH -> DONE after the last flush strobe; DONE SHALL assert frame_done for exactly one cycle and return to IDLE.
REQ-025 qam_valid SHALL be 0 and qam_in SHALL hold its last value outside strobe cycles.
REQ-026 The buffer SHALL be first-word-fall-through; s_ready=!full in every state; push when s_valid&&s_ready.
REQ-027 Push and pop in the same cycle SHALL leave the occupancy unchanged; a pop on empty or push on full SHALL never occur.
REQ-028 Samples arriving during IDLE, FLUSH or DONE SHALL be buffered for the next frame.
REQ-029 abort=1 in any state SHALL, next cycle: state IDLE, buffer emptied, qam_valid=0, divider and counters cleared, frame_done not pulsed; underrun SHALL be kept.
REQ-030 underrun SHALL clear only on reset or on an accepted start.
REQ-031 The sample counter SHALL be 16 bits; cfg_frame_len=65535 SHALL complete without wrap.

Reset
REQ-032 axi_rst=1 SHALL force state IDLE, buffer empty, divider and counters 0.
REQ-033 Output reset values SHALL be: s_ready=0 during reset (1 the cycle after), qam_valid=0, qam_in=0, busy=0, frame_done=0, underrun=0.
REQ-034 Reset mid-frame SHALL drop all buffered samples with no further strobes.

Structure
REQ-035 The state enum, sample width (10) and parameter defaults SHALL live in a shared package qam_pkg.
REQ-036 The buffer SHALL be a sub-module qam_sample_fifo (FWFT, parameter DEPTH, ports push/pop/data/full/empty).

Verification
REQ-037 Prefill 8 samples 1..8, cfg_frame_len=8, start at T -> qam_valid at T+5, T+9, ... T+33 carrying 1..8, then 32 zero strobes every 4 clocks, frame_done one cycle after the last.
REQ-038 Prefill 2 samples, frame_len=4, supply sample 3 ten cycles late -> one slot skipped, underrun=1, exactly 4 data strobes in order.
REQ-039 s_valid held high with no start -> 16 pushes, then s_ready=0; start with frame_len=16 -> the first pop re-raises s_ready, no sample lost or duplicated.
REQ-040 abort asserted mid-FLUSH -> next cycle IDLE, busy=0, no frame_done, buffer empty.
REQ-041 start with cfg_frame_len=0 -> stays IDLE, no strobes; SAMPLE_DIV=1 run -> strobes on consecutive cycles.
REQ-042 axi_rst asserted in RUN with 5 samples buffered -> all outputs at reset values next cycle; a following start with no new input yields only underrun.
